// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined datapath among several requesters.
// Each requester is only admitted while its response FIFO space is reserved, so results never stall.
module pipe_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     pipe_in_valid,
  output logic [WIDTH-1:0]         pipe_in_data,
  input  logic                     pipe_out_valid,
  input  logic [WIDTH-1:0]         pipe_out_data,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [NUM_REQ*WIDTH-1:0] resp_data,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     busy,
  output logic                     protocol_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(RESP_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(RESP_DEPTH);

  logic [IW-1:0]    rrPtr_q, rrPtr_d;
  logic             tagValid_q [LATENCY];
  logic [IW-1:0]    tagIdx_q   [LATENCY];
  logic [CW-1:0]    inflight_q [NUM_REQ];
  logic [CW-1:0]    count_q    [NUM_REQ];
  logic [PW-1:0]    wrPtr_q    [NUM_REQ];
  logic [PW-1:0]    rdPtr_q    [NUM_REQ];
  logic [WIDTH-1:0] mem_q      [NUM_REQ][RESP_DEPTH];
  logic             protocolError_q, protocolError_d;

  logic [NUM_REQ-1:0] eligible, grant, arrive, push, pop;
  logic               anyGrant;
  logic [IW-1:0]      grantIdx;
  logic               tailValid;
  logic [IW-1:0]      tailIdx;
  logic               anyTag, anyCount;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tailValid = tagValid_q[LATENCY-1];
  assign tailIdx   = tagIdx_q[LATENCY-1];

  // Credit covers both tags still in the datapath and results parked in the FIFO.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & ~rst &
                    (({1'b0, inflight_q[i]} + {1'b0, count_q[i]}) < DEPTH_C);
    end
  end

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!anyGrant && eligible[IW'((int'(rrPtr_q) + k) % NUM_REQ)]) begin
        anyGrant = 1'b1;
        grantIdx = IW'((int'(rrPtr_q) + k) % NUM_REQ);
      end
    end
    grant[grantIdx] = anyGrant;
    rrPtr_d = rrPtr_q;
    if (anyGrant) begin
      rrPtr_d = (grantIdx == IW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  assign req_ready     = grant;
  assign pipe_in_valid = anyGrant;
  assign pipe_in_data  = req_data[int'(grantIdx)*WIDTH +: WIDTH];

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    pop        = '0;
    arrive     = '0;
    push       = '0;
    anyTag     = 1'b0;
    anyCount   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = ~rst & (count_q[i] != '0);
      resp_data[i*WIDTH +: WIDTH] = mem_q[i][rdPtr_q[i]];
      pop[i]    = resp_valid[i] & resp_ready[i];
      arrive[i] = pipe_out_valid & tailValid & (tailIdx == IW'(i));
      // A full FIFO can still accept a push when its head leaves in the same cycle.
      push[i]   = arrive[i] & ((count_q[i] != FULL_C) | pop[i]);
      anyCount  = anyCount | (count_q[i] != '0);
    end
    for (int l = 0; l < LATENCY; l++) begin
      anyTag = anyTag | tagValid_q[l];
    end
    protocolError_d = protocolError_q | (pipe_out_valid != tailValid) | (|(arrive & ~push));
  end

  assign busy           = ~rst & (anyTag | anyCount);
  assign protocol_error = protocolError_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q         <= '0;
      protocolError_q <= 1'b0;
      for (int l = 0; l < LATENCY; l++) begin
        tagValid_q[l] <= 1'b0;
        tagIdx_q[l]   <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        inflight_q[i] <= '0;
        count_q[i]    <= '0;
        wrPtr_q[i]    <= '0;
        rdPtr_q[i]    <= '0;
      end
    end else begin
      rrPtr_q         <= rrPtr_d;
      protocolError_q <= protocolError_d;
      tagValid_q[0]   <= anyGrant;
      tagIdx_q[0]     <= grantIdx;
      for (int l = 1; l < LATENCY; l++) begin
        tagValid_q[l] <= tagValid_q[l-1];
        tagIdx_q[l]   <= tagIdx_q[l-1];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        inflight_q[i] <= inflight_q[i] + CW'(grant[i]) - CW'(arrive[i]);
        count_q[i]    <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) begin
          mem_q[i][wrPtr_q[i]] <= pipe_out_data;
          wrPtr_q[i]           <= incPtr(wrPtr_q[i]);
        end
        if (pop[i]) begin
          rdPtr_q[i] <= incPtr(rdPtr_q[i]);
        end
      end
    end
  end

endmodule
